// File: rtl/mem_fill_pkg.sv
// Shared types and helpers for the self-initialising scratch RAM and its fill/check engine.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        FILL_CONST  = 2'd0,
        FILL_INCR   = 2'd1,
        CHECK_CONST = 2'd2,
        CHECK_INCR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Wide enough for any sensible DATA_W; callers truncate, which gives the modulo sum.
    localparam int EXP_W = 64;

    function automatic logic [EXP_W-1:0] expected(input logic [EXP_W-1:0] pat,
                                                  input logic [EXP_W-1:0] k);
        return pat + k;
    endfunction

    function automatic logic mode_is_fill(input mode_e m);
        return (m == FILL_CONST) || (m == FILL_INCR);
    endfunction

    function automatic logic mode_is_incr(input mode_e m);
        return (m == FILL_INCR) || (m == CHECK_INCR);
    endfunction

endpackage

// File: rtl/mem_fill_engine_ram.sv
// Storage array: one synchronous write port shared by engine and host, two async read ports.
module mem_fill_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              run,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_din,
    output logic [DATA_W-1:0] eng_dout,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    // The engine owns the write port for the whole sweep; host writes are simply dropped.
    always_comb begin
        we = host_we;
        wa = host_addr;
        wd = host_din;
        if (run) begin
            we = eng_we;
            wa = eng_addr;
            wd = eng_din;
        end
    end

    always_ff @(posedge clock) begin
        if (we) mem[wa] <= wd;
    end

    assign host_dout = mem[host_addr];
    assign eng_dout  = mem[eng_addr];

endmodule

// File: rtl/mem_fill_engine.sv
// Scratch RAM with a windowed fill / read-back check engine, abort and host access port.
module mem_fill_engine
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int ERRC_W = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    input  logic              host_we,
    output logic [DATA_W-1:0] host_dout,
    input  logic [ADDR_W-1:0] cfg_lo,
    input  logic [ADDR_W-1:0] cfg_hi,
    input  logic [DATA_W-1:0] cfg_pat,
    input  logic [1:0]        cfg_mode,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ERRC_W-1:0] err_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_flag
);

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [ADDR_W-1:0] hi_q, cur_q, k_q;
    logic [DATA_W-1:0] pat_q;
    logic              busy_q, done_q;
    logic [ERRC_W-1:0] err_cnt_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic              start_go, active, last, is_fill, eng_we, mismatch;
    logic [ADDR_W-1:0] k_eff;
    logic [DATA_W-1:0] exp_data, eng_dout;

    assign start_go = (state_q == IDLE) && start;
    // The location presented on an abort (or reset) cycle is neither written nor checked.
    assign active   = (state_q == RUN) && !abort && !reset;
    assign last     = (cur_q == hi_q);
    assign is_fill  = mode_is_fill(mode_q);
    assign k_eff    = mode_is_incr(mode_q) ? k_q : '0;
    assign exp_data = DATA_W'(expected(EXP_W'(pat_q), EXP_W'(k_eff)));
    assign eng_we   = active && is_fill;
    assign mismatch = active && !is_fill && (eng_dout != exp_data);

    mem_fill_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock     (clock),
        .run       (state_q == RUN),
        .eng_we    (eng_we),
        .eng_addr  (cur_q),
        .eng_din   (exp_data),
        .eng_dout  (eng_dout),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN: begin
                if (abort)     state_d = IDLE;
                else if (last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q     <= FILL_CONST;
            hi_q       <= '0;
            pat_q      <= '0;
            cur_q      <= '0;
            k_q        <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (start_go) begin
            mode_q <= mode_e'(cfg_mode);
            hi_q   <= cfg_hi;
            pat_q  <= cfg_pat;
            cur_q  <= cfg_lo;
            k_q    <= '0;
            // A fill leaves the last check's results visible; a new check starts clean.
            if (cfg_mode[1]) begin
                err_cnt_q  <= '0;
                err_addr_q <= '0;
            end
        end else if (active) begin
            cur_q <= cur_q + 1'b1;
            k_q   <= k_q + 1'b1;
            if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                if (err_cnt_q == '0) err_addr_q <= cur_q;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;
    assign err_flag = (err_cnt_q != '0);

endmodule

// File: tb/tb_mem_fill_engine.sv
// Directed bench for mem_fill_engine: fills, wrap, checks, host drop, abort and reset mid-run.
module tb_mem_fill_engine;
    import mem_fill_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int EW = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_din = '0;
    logic          host_we = 1'b0;
    logic [DW-1:0] host_dout;
    logic [AW-1:0] cfg_lo = '0, cfg_hi = '0;
    logic [DW-1:0] cfg_pat = '0;
    logic [1:0]    cfg_mode = '0;
    logic          start = 1'b0, abort = 1'b0;
    logic          busy, done, err_flag;
    logic [EW-1:0] err_cnt;
    logic [AW-1:0] err_addr;

    int nchk = 0;
    int nerr = 0;
    int cyc;
    logic d0, d1;

    mem_fill_engine #(.ADDR_W(AW), .DATA_W(DW), .ERRC_W(EW)) dut (
        .clock(clock), .reset(reset),
        .host_addr(host_addr), .host_din(host_din), .host_we(host_we), .host_dout(host_dout),
        .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_pat(cfg_pat), .cfg_mode(cfg_mode),
        .start(start), .abort(abort), .busy(busy), .done(done),
        .err_cnt(err_cnt), .err_addr(err_addr), .err_flag(err_flag)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_addr = a;
        host_din  = d;
        host_we   = 1'b1;
        tick();
        host_we   = 1'b0;
    endtask

    task automatic host_chk(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        host_addr = a;
        #1;
        chk(tag, 32'(host_dout), exp);
    endtask

    // Leaves the bench one step after the start edge, i.e. in the first RUN cycle.
    task automatic go(input logic [1:0] m, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                      input logic [DW-1:0] pat);
        cfg_mode = m;
        cfg_lo   = lo;
        cfg_hi   = hi;
        cfg_pat  = pat;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c, output logic dn0, output logic dn1);
        c = c0;
        while (busy === 1'b1 && c < 100) begin
            c++;
            tick();
        end
        dn0 = done;
        tick();
        dn1 = done;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errc", 32'(err_cnt), 0);
        chk("rst_erra", 32'(err_addr), 0);
        chk("rst_errf", 32'(err_flag), 0);
        reset = 1'b0;
        tick();

        // FILL_CONST 3..6 with A5, neighbours preloaded
        host_wr(2, 'h11);
        host_wr(7, 'h22);
        go(FILL_CONST, 3, 6, 'hA5);
        wait_done(0, cyc, d0, d1);
        chk("t1_busy_cyc", 32'(cyc), 4);
        chk("t1_done", 32'(d0), 1);
        chk("t1_done_once", 32'(d1), 0);
        host_chk("t1_m2", 2, 'h11);
        host_chk("t1_m3", 3, 'hA5);
        host_chk("t1_m4", 4, 'hA5);
        host_chk("t1_m5", 5, 'hA5);
        host_chk("t1_m6", 6, 'hA5);
        host_chk("t1_m7", 7, 'h22);

        // FILL_INCR wrapping window 14..1
        go(FILL_INCR, 14, 1, 'hFE);
        wait_done(0, cyc, d0, d1);
        chk("t2_busy_cyc", 32'(cyc), 4);
        chk("t2_done", 32'(d0), 1);
        host_chk("t2_m14", 14, 'hFE);
        host_chk("t2_m15", 15, 'hFF);
        host_chk("t2_m0", 0, 'h00);
        host_chk("t2_m1", 1, 'h01);
        host_chk("t2_m2", 2, 'h11);

        // CHECK_INCR over the wrapped window: clean, then all-wrong seed
        go(CHECK_INCR, 14, 1, 'hFE);
        wait_done(0, cyc, d0, d1);
        chk("t2c_busy_cyc", 32'(cyc), 4);
        chk("t2c_errc", 32'(err_cnt), 0);
        chk("t2c_errf", 32'(err_flag), 0);
        go(CHECK_INCR, 14, 1, 'hFD);
        wait_done(0, cyc, d0, d1);
        chk("t2d_errc", 32'(err_cnt), 4);
        chk("t2d_erra", 32'(err_addr), 14);
        chk("t2d_errf", 32'(err_flag), 1);

        // Full-depth fill; host writes and a second start during RUN are dropped
        go(FILL_CONST, 5, 4, 'h00);
        host_addr = 9;
        host_din  = 'h77;
        host_we   = 1'b1;
        cfg_pat   = 'hFF;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        host_chk("t3_run_rd", 5, 'h00);
        tick();
        host_we   = 1'b0;
        wait_done(2, cyc, d0, d1);
        chk("t3_busy_cyc", 32'(cyc), 16);
        chk("t3_done", 32'(d0), 1);
        go(CHECK_CONST, 5, 4, 'h00);
        wait_done(0, cyc, d0, d1);
        chk("t3c_busy_cyc", 32'(cyc), 16);
        chk("t3c_errc", 32'(err_cnt), 0);
        chk("t3c_errf", 32'(err_flag), 0);
        host_chk("t3_m9", 9, 'h00);

        // Two corrupted words found by CHECK_CONST
        go(FILL_CONST, 0, 15, 'h10);
        wait_done(0, cyc, d0, d1);
        host_wr(7, 'h00);
        host_wr(11, 'h00);
        go(CHECK_CONST, 0, 15, 'h10);
        wait_done(0, cyc, d0, d1);
        chk("t4_errc", 32'(err_cnt), 2);
        chk("t4_erra", 32'(err_addr), 7);
        chk("t4_errf", 32'(err_flag), 1);

        // Abort in the third RUN cycle
        go(FILL_CONST, 0, 15, 'h3C);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        tick();
        chk("t5_done_nxt", 32'(done), 0);
        chk("t5_errc_kept", 32'(err_cnt), 2);
        host_chk("t5_m0", 0, 'h3C);
        host_chk("t5_m1", 1, 'h3C);
        host_chk("t5_m2", 2, 'h10);
        host_chk("t5_m3", 3, 'h10);

        // Reset mid-check, then a single-location fill started with abort also high
        go(CHECK_CONST, 0, 15, 'h10);
        tick();
        chk("t6_errc_pre", 32'(err_cnt), 1);
        reset = 1'b1;
        tick();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_errc", 32'(err_cnt), 0);
        chk("t6_errf", 32'(err_flag), 0);
        reset = 1'b0;
        tick();
        abort = 1'b1;
        go(FILL_CONST, 4, 4, 'h55);
        abort = 1'b0;
        wait_done(0, cyc, d0, d1);
        chk("t6_busy_cyc", 32'(cyc), 1);
        chk("t6_done", 32'(d0), 1);
        host_chk("t6_m4", 4, 'h55);
        host_chk("t6_m5", 5, 'h10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_fill_engine.md
Name: mem_fill_engine

Overview:
Parametrised on-chip RAM with a built-in fill/check engine. It generalises the earlier zero-fill controller in four ways: a programmable inclusive address window that may wrap, a constant or incrementing fill pattern, a read-back check mode with error reporting, and an abort input. A host port gives normal read/write access when the engine is idle. The block sits beside the datapath as a self-initialising scratch memory with built-in self-test.

Parameters:
ADDR_W, 8, address width; depth = 2**ADDR_W
DATA_W, 8, data word width
ERRC_W, 9, error counter width (default ADDR_W+1, so a full-depth sweep can never saturate)

Ports:
clock      in   1        clock; all state updates on its rising edge
reset      in   1        synchronous, active-high reset
host_addr  in   ADDR_W   host read/write address
host_din   in   DATA_W   host write data
host_we    in   1        host write enable
host_dout  out  DATA_W   asynchronous read of mem[host_addr], valid in every state
cfg_lo     in   ADDR_W   first address of window
cfg_hi     in   ADDR_W   last address of window (inclusive)
cfg_pat    in   DATA_W   seed pattern
cfg_mode   in   2        operation select, see Behaviour
start      in   1        begin operation; sampled only in IDLE
abort      in   1        terminate running operation
busy       out  1        registered; high while the engine owns memory
done       out  1        one-cycle pulse on normal completion
err_cnt    out  ERRC_W   mismatches found in last check (saturating)
err_addr   out  ADDR_W   address of first mismatch in last check
err_flag   out  1        err_cnt != 0

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, err_cnt=0, err_addr=0, err_flag=0.
  - Memory contents are NOT cleared.
- cfg_mode values:
  - 0 FILL_CONST: write cfg_pat.
  - 1 FILL_INCR: write cfg_pat+k.
  - 2 CHECK_CONST: compare against cfg_pat.
  - 3 CHECK_INCR: compare against cfg_pat+k.
  - k = offset from cfg_lo; the sum is modulo 2**DATA_W.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE & start (edge E0):
  - Latch lo, hi, pat and mode.
  - Set cur=lo, k=0, busy=1.
  - For check modes, also clear err_cnt, err_addr and err_flag at E0.
- RUN, one address per cycle:
  - Fill: mem[cur] written at the next edge.
  - Check: compare mem[cur] (async read) with the expected value; on mismatch increment err_cnt (saturating at all-ones), and if it was 0, load err_addr=cur.
  - cur and k increment modulo 2**ADDR_W.
- Termination:
  - On the edge that processes cur==hi: go to DONE and set busy=0.
  - In DONE: done=1 for exactly one cycle, then IDLE.
  - An N-location window gives busy high for exactly N cycles.
- Window:
  - lo<=hi: N=hi-lo+1.
  - lo>hi: wraps through 2**ADDR_W-1 to 0; N=2**ADDR_W-lo+hi+1.
  - lo==hi: N=1.
  - Full depth is lo=hi+1 (mod 2**ADDR_W).
- Host port:
  - host_we is honoured only in IDLE and DONE.
  - During RUN, host_we is dropped (no queueing) and host_dout still reads mem[host_addr].
- start while busy: ignored.
- cfg_* changes during RUN: no effect, because values were latched at E0.
- abort:
  - Takes priority over everything in RUN.
  - Next edge: IDLE, busy=0, no done pulse.
  - Locations already written stay written; the location presented on the abort cycle is NOT written or checked.
  - Error registers keep their partial values.
  - abort in IDLE: no effect; start&abort in IDLE: start wins.
- Reset mid-RUN: same as abort, but the error registers are also cleared.

Decomposition:
- Package mem_fill_pkg:
  - mode_e enum {FILL_CONST, FILL_INCR, CHECK_CONST, CHECK_INCR} (2 bits).
  - state_e enum {IDLE, RUN, DONE}.
  - Helper function expected(pat, k).
- Sub-module mem_fill_ram #(ADDR_W, DATA_W):
  - One synchronous write port, two asynchronous read ports (host, engine).
  - Write mux: engine when RUN, otherwise host.
- Top level holds the FSM, the address/offset counters and the error logic.

Test Plan:
- ADDR_W=4, DATA_W=8, mode FILL_CONST, lo=3, hi=6, pat=8'hA5 -> busy exactly 4 cycles; done pulses once; mem[3..6]=A5; mem[2] and mem[7] unchanged.
- mode FILL_INCR, lo=14, hi=1, pat=8'hFE -> wrap; busy 4 cycles; mem[14]=FE, mem[15]=FF, mem[0]=00, mem[1]=01.
- Fill full depth (lo=5, hi=4) with 8'h00; host writes 8'h77 to addr 9 at start+1; then CHECK_CONST pat=00 -> busy 16 cycles; host write dropped; err_cnt=0, err_flag=0.
- After filling 0..15 with 8'h10, host writes 8'h00 to addr 7 and addr 11; then CHECK_CONST pat=10, lo=0, hi=15 -> err_cnt=2, err_addr=7, err_flag=1.
- FILL_CONST lo=0, hi=15, pat=8'h3C; abort asserted in the 3rd RUN cycle -> mem[0..1]=3C, mem[2] unchanged; busy low next cycle; no done pulse.
- Reset asserted mid-check with err_cnt=1 -> busy=0, err_cnt=0 next edge; a subsequent start with lo=hi=4 gives busy for exactly 1 cycle.
